mem_lane_reader: RTL
====================

Name: mem_lane_reader

Overview:
Read-side counterpart to the data_memory write path. On command it fetches a run of consecutive 128-bit words from data_memory. It unpacks each word into 16-bit elements and streams them to the histogram datapath over a valid/ready interface. It owns the memory read port (address and read enable) and runs one word-fetch at a time with no prefetch.

Parameters:
DATA_W, 128, memory word width in bits
ELEM_W, 16, element width; LANES = DATA_W/ELEM_W (8), derived, DATA_W must be a multiple of ELEM_W
ADDR_W, 8, memory address width
RD_LAT, 1, memory read latency in cycles from mem_rd_en edge to mem_rdata valid (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
base_addr  in  ADDR_W  first word address, latched on accepted start
num_words  in  ADDR_W+1  words to read, latched on accepted start; 0 allowed
mem_addr  out  ADDR_W  read address to data_memory
mem_rd_en  out  1  read strobe, one cycle per word
mem_rdata  in  DATA_W  read data from data_memory
out_valid  out  1  element available
out_ready  in  1  consumer accepts element
out_data  out  ELEM_W  current element
out_last  out  1  marks final element of the run
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0 (mem_addr=0, mem_rd_en=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0); word buffer, lane index and counters cleared. Reset mid-run aborts immediately. No partial element is presented after reset.
- States: IDLE, REQ, WAIT, STREAM, DONE.
- IDLE: if start=1, latch base_addr and num_words.
  - If num_words=0, go to DONE.
  - Otherwise go to REQ.
- REQ: one cycle with mem_rd_en=1 and mem_addr=current address. Then go to WAIT.
- WAIT: lasts exactly RD_LAT cycles. mem_rdata is captured into the word buffer on the last WAIT edge. Lane index is set to 0. Then go to STREAM.
- STREAM:
  - out_valid=1 and out_data = buffer[ELEM_W*idx +: ELEM_W]. Lane 0 is bits [15:0] and goes first.
  - On out_valid & out_ready, idx increments.
  - On the handshake of lane LANES-1: decrement remaining words and increment the address (mod 2^ADDR_W, wraps 255->0). Go to REQ if words remain, else go to DONE.
- out_last=1 only while presenting lane LANES-1 of the final word.
- DONE: done=1 for one cycle, busy stays 1, then go to IDLE.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and all state are held stable.
- start is ignored when not in IDLE. Latched parameters are unaffected by input changes mid-run.
- Timing with RD_LAT=1 and out_ready=1: start accepted at edge E0; REQ between E0 and E1; WAIT between E1 and E2; first out_valid after E2. Each word takes 8 stream cycles plus 2 bubble cycles (REQ+WAIT).
- mem_rd_en is never asserted outside REQ. There is at most one outstanding read.

Decomposition:
- Shared package hist_pkg holds:
  - constants DATA_W, ELEM_W, LANES, ADDR_W
  - typedef word_t (logic [DATA_W-1:0])
  - typedef elem_t (logic [ELEM_W-1:0])
  - enum rd_state_t {IDLE, REQ, WAIT, STREAM, DONE}
- One natural sub-module: lane_unpacker. It holds the word buffer and lane index, does capture/select, and generates the last-lane flag.
- The FSM and address/word counters stay in mem_lane_reader.

Test Plan:
- Single word: mem[0]=128'h000C000F00050001000B00030008000A, base_addr=0, num_words=1, out_ready=1 -> out_data 000A,0008,0003,000B,0001,0005,000F,000C on consecutive cycles. First valid comes 3 edges after start. out_last only on 000C, done pulse on the following cycle, exactly one mem_rd_en.
- Two words with backpressure: mem[4]=all-lanes 0x7E7E, mem[5]=lanes 0..7=0x0081..0x0088, base_addr=4, num_words=2. Toggle out_ready every other cycle -> 16 elements in order, data held stable while stalled, mem_addr sequence 4 then 5, out_last only on 0x0088.
- Zero length: num_words=0 -> no mem_rd_en, no out_valid, busy high 1 cycle, done pulse on 2nd edge after start.
- Address wrap: base_addr=255, num_words=2 -> mem_addr 255 then 0, 16 elements emitted.
- Start while busy and reset mid-run: pulse start with new base_addr during STREAM -> ignored. Assert rst_n=0 for one edge after 3 elements of a 1-word run -> all outputs 0 next cycle, no done pulse. A new start then reruns from scratch.
- RD_LAT=3 build: single word as in scenario 1 -> first out_valid 5 edges after start, and capture happens from the correct mem_rdata cycle.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram read path.
// Word/element geometry and the lane reader FSM encoding.
package hist_pkg;

  localparam int DATA_W = 128;
  localparam int ELEM_W = 16;
  localparam int LANES  = DATA_W / ELEM_W;
  localparam int ADDR_W = 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM,
    DONE
  } rd_state_t;

endpackage

// File: rtl/lane_unpacker.sv
// Holds one fetched memory word and walks its lanes.
// Lane 0 (least significant element) is presented first.
module lane_unpacker #(
  parameter int DATA_W = hist_pkg::DATA_W,
  parameter int ELEM_W = hist_pkg::ELEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              adv_i,
  output logic [ELEM_W-1:0] elem_o,
  output logic              last_lane_o
);

  localparam int LANES = DATA_W / ELEM_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [DATA_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  assign last_lane_o = (idx_q == IDX_W'(LANES - 1));
  assign elem_o      = buf_q[ELEM_W*idx_q +: ELEM_W];

  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    if (cap_i) begin
      buf_d = word_i;
      idx_d = '0;
    end else if (adv_i) begin
      idx_d = last_lane_o ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q <= '0;
      idx_q <= '0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/mem_lane_reader.sv
// Fetches a run of memory words, one at a time, and streams
// their 16-bit lanes to the histogram datapath.
module mem_lane_reader
  import hist_pkg::*;
#(
  parameter int DATA_W = hist_pkg::DATA_W,
  parameter int ELEM_W = hist_pkg::ELEM_W,
  parameter int ADDR_W = hist_pkg::ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic              lat_end;
  logic              cap;
  logic              hs;
  logic              last_lane;
  logic              final_word;
  logic [ELEM_W-1:0] elem;

  assign lat_end    = (lat_q == LAT_W'(RD_LAT - 1));
  assign cap        = (state_q == WAIT) && lat_end;
  assign hs         = (state_q == STREAM) && out_ready;
  assign final_word = (words_q == (ADDR_W+1)'(1));

  lane_unpacker #(
    .DATA_W(DATA_W),
    .ELEM_W(ELEM_W)
  ) u_unpack (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_i      (cap),
    .word_i     (mem_rdata),
    .adv_i      (hs),
    .elem_o     (elem),
    .last_lane_o(last_lane)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      words_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_words == '0) ? DONE : REQ;
        end
      end
      REQ:  state_d = WAIT;
      WAIT: begin
        if (lat_end) state_d = STREAM;
      end
      STREAM: begin
        if (hs && last_lane) begin
          state_d = final_word ? DONE : REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and word count move together on the last lane handshake.
  always_comb begin
    addr_d  = addr_q;
    words_d = words_q;
    lat_d   = lat_q;
    if (state_q == IDLE && start) begin
      addr_d  = base_addr;
      words_d = num_words;
    end
    if (state_q == REQ) lat_d = '0;
    if (state_q == WAIT && !lat_end) lat_d = lat_q + 1'b1;
    if (hs && last_lane) begin
      addr_d  = addr_q + 1'b1;
      words_d = words_q - 1'b1;
    end
  end

  always_comb begin
    mem_rd_en = (state_q == REQ);
    mem_addr  = addr_q;
    out_valid = (state_q == STREAM);
    out_data  = out_valid ? elem : '0;
    out_last  = out_valid && last_lane && final_word;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

endmodule
